// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the MMIO UART blocks
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [7:0] TX_ADDR_DEF   = 8'hFE;
    localparam logic [7:0] STAT_ADDR_DEF = 8'hFD;

    localparam int BUSY = 0;
    localparam int FULL = 1;
    localparam int OVF  = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-memory bus slice seen by the UART transmitter
interface uart_tx_mmio_if;
    logic [7:0] Address;
    logic       we;
    logic [7:0] RegData;
    logic [7:0] StatusOut;

    modport master (output Address, we, RegData, input StatusOut);
    modport slave  (input Address, we, RegData, output StatusOut);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 4x8 synchronous FIFO; a push while full is accepted only if a pop frees a slot
module uart_tx_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);
    logic [7:0] mem [4];
    logic [1:0] wp, rp;
    logic       do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];
    assign full    = count == 3'd4;
    assign empty   = count == 3'd0;

    // pointers and occupancy; pointers wrap modulo 4
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + {1'b0, do_push};
            rp    <= rp + {1'b0, do_pop};
            count <= count + {2'b0, do_push} - {2'b0, do_pop};
        end
    end

    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a 4-deep FIFO and pollable status
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] TX_ADDR   = TX_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_mmio_if.slave  bus,
    output logic           txd,
    output logic           busy
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

    tx_state_t   state, state_n;
    logic [BW-1:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sh;
    logic [7:0]  dout;
    logic [2:0]  count;
    logic        full, empty, push, pop, clr, ovf_set, ovf, baud_end;

    assign push     = bus.we && bus.Address == TX_ADDR;
    assign clr      = bus.we && bus.Address == STAT_ADDR && bus.RegData[2];
    assign pop      = state == IDLE && !empty;
    assign ovf_set  = push && full && !pop;
    assign baud_end = baud_cnt == BW'(CPB - 1);
    assign busy     = state != IDLE || count != 3'd0;
    assign txd      = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;

    uart_tx_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.RegData),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // status word assembled from registered state
    always_comb begin
        bus.StatusOut      = '0;
        bus.StatusOut[BUSY] = busy;
        bus.StatusOut[FULL] = full;
        bus.StatusOut[OVF]  = ovf;
    end

    // sticky overflow; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (clr)
            ovf <= 1'b0;
    end

    // next-state logic for the frame sequencer
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = empty ? IDLE : START;
            START:   state_n = baud_end ? DATA : START;
            DATA:    state_n = (baud_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    state_n = baud_end ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // state, baud timing, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= (state_n != state || baud_end) ? '0 : baud_cnt + 1'b1;
            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && baud_end)
                bit_idx <= bit_idx + 3'd1;
            if (pop)
                sh <= dout;
            else if (state == DATA && baud_end)
                sh <= {1'b0, sh[7:1]};
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed tests of the MMIO UART transmitter at 4 clocks per bit
module tb_uart_tx_mmio;
    localparam logic [7:0] TXA = 8'hFE;
    localparam logic [7:0] STA = 8'hFD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, busy;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [7:0] rx_b[$];
    int         rx_c[$];

    uart_tx_mmio_if bus();

    uart_tx_mmio #(.CLK_FREQ(1000), .BAUD(250)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .txd  (txd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // line receiver: frame bit k occupies cycles start+4k..start+4k+3, sampled mid-bit
    initial begin
        int pos;
        int mstart;
        logic [7:0] mbyte;
        pos = -1;
        mstart = 0;
        mbyte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = -1;
            end else if (pos < 0) begin
                if (txd === 1'b0) begin
                    pos = 0;
                    mstart = cyc;
                end
            end else begin
                pos++;
                if (pos == 2) begin
                    total++;
                    if (txd !== 1'b0) begin
                        bad++;
                        $display("FAIL start_bit: txd=%b required 0 (cyc %0d)", txd, cyc);
                    end
                end
                if (pos >= 6 && pos <= 34 && pos % 4 == 2)
                    mbyte = {txd, mbyte[7:1]};
                if (pos == 38) begin
                    total++;
                    if (txd !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: txd=%b required 1 (cyc %0d)", txd, cyc);
                    end
                    rx_b.push_back(mbyte);
                    rx_c.push_back(mstart);
                    pos = -1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        bus.Address = a;
        bus.RegData = d;
        bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        bus.Address = 8'h00;
        bus.RegData = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_b.delete();
        rx_c.delete();
    endtask

    task automatic wait_frames(input int n, input int lim);
        int k;
        k = 0;
        while (rx_b.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (rx_b.size() < n) begin
            bad++;
            $display("FAIL frame_wait: got %0d frames required %0d", rx_b.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) begin
            total++;
            if ({txd, busy, bus.StatusOut} !== {1'b1, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL reset_idle: txd=%b busy=%b status=%h required 1 0 00", txd, busy, bus.StatusOut);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        int c, nb;
        do_reset();
        c = cyc;
        store(TXA, 8'hA5);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise: busy=%b required 1", busy);
        end
        // one cycle with the byte queued, then the 40-cycle frame
        nb = 0;
        repeat (50) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
        end
        total++;
        if (nb != 41) begin
            bad++;
            $display("FAIL busy_len: busy cycles=%0d required 41", nb);
        end
        wait_frames(1, 50);
        if (rx_b.size() >= 1) begin
            total++;
            if (rx_b[0] !== 8'hA5) begin
                bad++;
                $display("FAIL single_byte: got %h required a5", rx_b[0]);
            end
            total++;
            if (rx_c[0] != c + 2) begin
                bad++;
                $display("FAIL start_latency: start cyc=%0d required %0d", rx_c[0], c + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        c = cyc;
        for (int i = 1; i <= 6; i++) store(TXA, 8'(i));
        total++;
        if (bus.StatusOut !== 8'h07) begin
            bad++;
            $display("FAIL overflow_status: status=%h required 07", bus.StatusOut);
        end
        wait_frames(5, 300);
        for (int i = 0; i < 5 && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, rx_b[i], 8'(i + 1));
            end
            total++;
            if (rx_c[i] != c + 2 + 41 * i) begin
                bad++;
                $display("FAIL b2b_start%0d: start cyc=%0d required %0d", i, rx_c[i], c + 2 + 41 * i);
            end
        end
        repeat (60) @(negedge clk);
        total++;
        if (rx_b.size() != 5) begin
            bad++;
            $display("FAIL dropped_byte: frames=%0d required 5", rx_b.size());
        end
    endtask

    task automatic test_stat();
        total++;
        if (bus.StatusOut !== 8'h04) begin
            bad++;
            $display("FAIL ovf_sticky: status=%h required 04", bus.StatusOut);
        end
        store(8'h10, 8'hFF);
        total++;
        if ({busy, bus.StatusOut} !== {1'b0, 8'h04}) begin
            bad++;
            $display("FAIL other_addr: busy=%b status=%h required 0 04", busy, bus.StatusOut);
        end
        repeat (10) @(negedge clk);
        total++;
        if (rx_b.size() != 5 || txd !== 1'b1) begin
            bad++;
            $display("FAIL other_addr_tx: frames=%0d txd=%b required 5 1", rx_b.size(), txd);
        end
        store(STA, 8'hFB);
        total++;
        if (bus.StatusOut !== 8'h04) begin
            bad++;
            $display("FAIL clr_bit2_zero: status=%h required 04", bus.StatusOut);
        end
        store(STA, 8'h04);
        total++;
        if (bus.StatusOut !== 8'h00) begin
            bad++;
            $display("FAIL ovf_clear: status=%h required 00", bus.StatusOut);
        end
    endtask

    task automatic test_push_on_pop();
        int c;
        logic [7:0] exp [6];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C};
        do_reset();
        c = cyc;
        for (int i = 0; i < 5; i++) store(TXA, exp[i]);
        total++;
        if (bus.StatusOut !== 8'h03) begin
            bad++;
            $display("FAIL fifo_full: status=%h required 03", bus.StatusOut);
        end
        // first frame occupies c+2..c+41; the pop happens on the edge closing cycle c+42
        repeat (37) @(negedge clk);
        total++;
        if (bus.StatusOut !== 8'h03) begin
            bad++;
            $display("FAIL full_before_pop: status=%h required 03", bus.StatusOut);
        end
        store(TXA, 8'h3C);
        total++;
        if (bus.StatusOut !== 8'h03) begin
            bad++;
            $display("FAIL push_on_pop: status=%h required 03", bus.StatusOut);
        end
        wait_frames(6, 400);
        for (int i = 0; i < 6 && i < rx_b.size(); i++) begin
            total++;
            if (rx_b[i] !== exp[i]) begin
                bad++;
                $display("FAIL pop_push_byte%0d: got %h required %h", i, rx_b[i], exp[i]);
            end
        end
        if (rx_c.size() >= 6) begin
            total++;
            if (rx_c[5] != c + 2 + 41 * 5) begin
                bad++;
                $display("FAIL pop_push_start: start cyc=%0d required %0d", rx_c[5], c + 2 + 41 * 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic line_ok;
        do_reset();
        store(TXA, 8'hFF);
        store(TXA, 8'h01);
        store(TXA, 8'h02);
        repeat (12) @(negedge clk);
        total++;
        if (bus.StatusOut !== 8'h01) begin
            bad++;
            $display("FAIL mid_frame_status: status=%h required 01", bus.StatusOut);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({txd, busy, bus.StatusOut} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL mid_reset: txd=%b busy=%b status=%h required 1 0 00", txd, busy, bus.StatusOut);
        end
        rst = 1'b0;
        line_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        total++;
        if (!line_ok || rx_b.size() != 0) begin
            bad++;
            $display("FAIL after_reset_quiet: line_ok=%b frames=%0d required 1 0", line_ok, rx_b.size());
        end
    endtask

    initial begin
        bus.Address = 8'h00;
        bus.RegData = 8'h00;
        bus.we = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stat();
        test_push_on_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
